// File: rtl/alarm_clk_pkg.sv
// Shared types and limits for the alarm clock datapath.
// Time is kept as packed binary hour/minute/second fields.
package alarm_clk_pkg;

  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_SEC  = 6'd59;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } time_t;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

endpackage

// File: rtl/time_keeper_tick_gen.sv
// Free-running prescaler: one tick per CLK_HZ enabled cycles.
// Tick is high in the cycle the count sits at CLK_HZ-1.
module tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(CLK_HZ - 1);

  logic [W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 24h time-of-day counter with RUN/SET modes and button-driven
// hour/minute setting; feeds the 12/24h display formatter.
module time_keeper
  import alarm_clk_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_mode,
  input  logic        inc_hour,
  input  logic        inc_min,
  output logic [16:0] time_out,
  output logic        sec_pulse,
  output logic        day_wrap
);

  state_t r_state;
  time_t  r_time;
  logic   r_hour_q;
  logic   r_min_q;
  logic   r_sec_pulse;
  logic   r_day_wrap;

  logic w_run;
  logic w_en;
  logic w_tick;
  logic w_hour_edge;
  logic w_min_edge;
  logic w_sec_max;
  logic w_min_max;
  logic w_hour_max;

  assign w_run       = (r_state == ST_RUN);
  // Prescaler stops on the cycle we leave RUN so no tick races the clear.
  assign w_en        = w_run && !set_mode;
  assign w_hour_edge = inc_hour && !r_hour_q;
  assign w_min_edge  = inc_min && !r_min_q;
  assign w_sec_max   = (r_time.sec >= MAX_SEC);
  assign w_min_max   = (r_time.min >= MAX_MIN);
  assign w_hour_max  = (r_time.hour >= MAX_HOUR);

  tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (!w_en),
    .i_en   (w_en),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      unique case (r_state)
        ST_RUN:  if (set_mode)  r_state <= ST_SET;
        ST_SET:  if (!set_mode) r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hour_q <= 1'b0;
      r_min_q  <= 1'b0;
    end else begin
      r_hour_q <= inc_hour;
      r_min_q  <= inc_min;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_time      <= '0;
      r_sec_pulse <= 1'b0;
      r_day_wrap  <= 1'b0;
    end else begin
      r_sec_pulse <= 1'b0;
      r_day_wrap  <= 1'b0;
      if (w_run) begin
        if (set_mode) begin
          r_time.sec <= '0;
        end else if (w_tick) begin
          r_sec_pulse <= 1'b1;
          if (!w_sec_max) begin
            r_time.sec <= r_time.sec + 6'd1;
          end else begin
            r_time.sec <= '0;
            if (!w_min_max) begin
              r_time.min <= r_time.min + 6'd1;
            end else begin
              r_time.min <= '0;
              if (!w_hour_max) begin
                r_time.hour <= r_time.hour + 5'd1;
              end else begin
                r_time.hour <= '0;
                r_day_wrap  <= 1'b1;
              end
            end
          end
        end
      end else begin
        if (w_hour_edge) begin
          r_time.hour <= w_hour_max ? 5'd0 : r_time.hour + 5'd1;
        end
        if (w_min_edge) begin
          r_time.min <= w_min_max ? 6'd0 : r_time.min + 6'd1;
        end
      end
    end
  end

  assign time_out  = r_time;
  assign sec_pulse = r_sec_pulse;
  assign day_wrap  = r_day_wrap;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper at CLK_HZ=4: stimulus queues
// expected snapshots and pulses, a negedge monitor retires them.
module tb_time_keeper;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_mode = 1'b0;
  logic        inc_hour = 1'b0;
  logic        inc_min = 1'b0;
  logic [16:0] time_out;
  logic        sec_pulse;
  logic        day_wrap;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    int          at;
    logic [16:0] t;
    logic        w;
  } chk_t;

  chk_t tq[$];
  chk_t pq[$];

  time_keeper #(
    .CLK_HZ (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .set_mode  (set_mode),
    .inc_hour  (inc_hour),
    .inc_min   (inc_min),
    .time_out  (time_out),
    .sec_pulse (sec_pulse),
    .day_wrap  (day_wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    return {h[4:0], m[5:0], s[5:0]};
  endfunction

  function automatic void push_t(input string n, input int at, input logic [16:0] t);
    chk_t c;
    c.name = n; c.at = at; c.t = t; c.w = 1'b0;
    tq.push_back(c);
  endfunction

  function automatic void push_p(input string n, input int at, input logic [16:0] t,
                                 input logic w);
    chk_t c;
    c.name = n; c.at = at; c.t = t; c.w = w;
    pq.push_back(c);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic h, input logic m);
    inc_hour = h;
    inc_min  = m;
    step(1);
    inc_hour = 1'b0;
    inc_min  = 1'b0;
    step(1);
  endtask

  // Monitor: snapshots retire on their cycle, pulses retire when seen.
  always @(negedge clk) begin
    for (int i = tq.size() - 1; i >= 0; i--) begin
      if (tq[i].at <= cyc) begin
        n_tests++;
        if (tq[i].at < cyc) begin
          n_fail++;
          $display("FAIL %s: snapshot missed at cycle %0d (now %0d)", tq[i].name,
                   tq[i].at, cyc);
        end else if (time_out !== tq[i].t) begin
          n_fail++;
          $display("FAIL %s: time_out=%h expected %h", tq[i].name, time_out, tq[i].t);
        end
        tq.delete(i);
      end
    end
    if (sec_pulse === 1'b1) begin
      n_tests++;
      if (pq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: sec_pulse=1 at cycle %0d expected 0", cyc);
      end else begin
        chk_t e;
        e = pq.pop_front();
        if (e.at != cyc || time_out !== e.t || day_wrap !== e.w) begin
          n_fail++;
          $display("FAIL %s: pulse cyc=%0d time=%h wrap=%b expected cyc=%0d time=%h wrap=%b",
                   e.name, cyc, time_out, day_wrap, e.at, e.t, e.w);
        end
      end
    end else if (day_wrap === 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL lone_day_wrap: day_wrap=1 sec_pulse=%b expected both 0", sec_pulse);
    end
    while (pq.size() > 0 && pq[0].at < cyc) begin
      chk_t e;
      e = pq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: no pulse at cycle %0d expected time %h", e.name, e.at, e.t);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k, q, r, u;

    // Reset and first two seconds.
    step(3);
    push_t("reset_state", cyc, 17'd0);
    reset = 1'b0;
    k = cyc;
    push_t("pre_tick", k + 3, 17'd0);
    push_p("pulse1", k + 4, hms(0, 0, 1), 1'b0);
    push_t("sec1", k + 5, hms(0, 0, 1));
    push_p("pulse2", k + 8, hms(0, 0, 2), 1'b0);
    step(9);

    // Buttons in RUN have no effect.
    push_p("pulse3", k + 12, hms(0, 0, 3), 1'b0);
    inc_hour = 1'b1; inc_min = 1'b1; step(1);
    inc_hour = 1'b0; inc_min = 1'b0; step(1);
    inc_hour = 1'b1; inc_min = 1'b1; step(1);
    push_t("run_ignore", k + 12, hms(0, 0, 3));
    inc_hour = 1'b0; inc_min = 1'b0; step(1);

    // Enter SET, build 23:30, dual press, then 23:59.
    set_mode = 1'b1;
    step(1);
    push_t("set_entry", cyc, 17'd0);
    for (int i = 0; i < 23; i++) press(1'b1, 1'b0);
    push_t("set_23", cyc, hms(23, 0, 0));
    for (int i = 0; i < 30; i++) press(1'b0, 1'b1);
    push_t("set_2330", cyc, hms(23, 30, 0));
    press(1'b1, 1'b1);
    push_t("dual_press", cyc, hms(0, 31, 0));
    for (int i = 0; i < 23; i++) press(1'b1, 1'b0);
    for (int i = 0; i < 28; i++) press(1'b0, 1'b1);
    push_t("set_2359", cyc, hms(23, 59, 0));

    // Run to 23:59:59 and across midnight.
    set_mode = 1'b0;
    q = cyc;
    for (int n = 1; n < 60; n++) push_p("run_up", q + 1 + 4 * n, hms(23, 59, n), 1'b0);
    push_t("pre_wrap", q + 240, hms(23, 59, 59));
    push_p("day_wrap", q + 241, 17'd0, 1'b1);
    push_t("post_wrap", q + 242, 17'd0);
    step(243);

    // Preload 10:20, run to 10:20:35, re-enter SET.
    set_mode = 1'b1;
    step(1);
    for (int i = 0; i < 10; i++) press(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) press(1'b0, 1'b1);
    push_t("set_1020", cyc, hms(10, 20, 0));
    set_mode = 1'b0;
    r = cyc;
    for (int n = 1; n <= 35; n++) push_p("run_1020", r + 1 + 4 * n, hms(10, 20, n), 1'b0);
    push_t("at_102035", r + 141, hms(10, 20, 35));
    step(142);
    set_mode = 1'b1;
    step(1);
    push_t("sec_clear", cyc, hms(10, 20, 0));
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
    push_t("min_plus3", cyc, hms(10, 23, 0));
    for (int i = 0; i < 36; i++) press(1'b0, 1'b1);
    push_t("min_59", cyc, hms(10, 59, 0));
    press(1'b0, 1'b1);
    push_t("min_wrap", cyc, hms(10, 0, 0));
    step(20);
    push_t("set_hold", cyc, hms(10, 0, 0));

    // 05:06:07 in RUN, reset mid-count with inc_hour held.
    for (int i = 0; i < 19; i++) press(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) press(1'b0, 1'b1);
    push_t("set_0506", cyc, hms(5, 6, 0));
    set_mode = 1'b0;
    u = cyc;
    for (int n = 1; n <= 7; n++) push_p("run_0506", u + 1 + 4 * n, hms(5, 6, n), 1'b0);
    step(30);
    push_t("at_050607", cyc, hms(5, 6, 7));
    inc_hour = 1'b1;
    reset = 1'b1;
    step(1);
    push_t("rst_mid", cyc, 17'd0);
    reset = 1'b0;
    k = cyc;
    push_p("rst_pulse", k + 4, hms(0, 0, 1), 1'b0);
    step(5);
    set_mode = 1'b1;
    step(1);
    step(3);
    push_t("held_no_inc", cyc, 17'd0);
    inc_hour = 1'b0;
    step(1);
    press(1'b1, 1'b0);
    push_t("repress", cyc, hms(1, 0, 0));

    // Reset taken while in SET.
    reset = 1'b1;
    set_mode = 1'b0;
    step(1);
    push_t("rst_in_set", cyc, 17'd0);
    reset = 1'b0;
    k = cyc;
    push_p("rst_set_pulse", k + 4, hms(0, 0, 1), 1'b0);
    step(6);

    @(negedge clk);
    #1;
    while (tq.size() > 0) begin
      chk_t e;
      e = tq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: snapshot never checked, expected %h", e.name, e.t);
    end
    while (pq.size() > 0) begin
      chk_t e;
      e = pq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: pulse never seen, expected time %h", e.name, e.t);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
